// File: rtl/tetris_pkg.sv
// Shared definitions for the tetromino placement search:
// board geometry, piece ids, shape masks and FSM states.
package tetris_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    typedef enum logic [2:0] {
        P_I, P_O, P_T, P_S, P_Z, P_J, P_L
    } piece_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DROP, S_REQ, S_WAIT, S_CMP, S_DONE
    } state_e;

    // [piece][rot], bit 4*r+c, top row and left column always occupied
    localparam logic [15:0] SHAPES [7][4] = '{
        '{16'h000F, 16'h1111, 16'h000F, 16'h1111},
        '{16'h0033, 16'h0033, 16'h0033, 16'h0033},
        '{16'h0027, 16'h0232, 16'h0072, 16'h0131},
        '{16'h0036, 16'h0231, 16'h0036, 16'h0231},
        '{16'h0063, 16'h0132, 16'h0063, 16'h0132},
        '{16'h0071, 16'h0113, 16'h0047, 16'h0322},
        '{16'h0074, 16'h0311, 16'h0017, 16'h0223}
    };

endpackage

// File: rtl/piece_shape_rom.sv
// Shape lookup: (piece, rot) -> 4x4 mask plus occupied width/height.
// Unknown piece codes return an empty mask.
module piece_shape_rom
    import tetris_pkg::*;
(
    input  logic [2:0]  piece,
    input  logic [1:0]  rot,
    output logic [15:0] mask,
    output logic [2:0]  width,
    output logic [2:0]  height
);

    logic [3:0] col_any;
    logic [3:0] row_any;

    // Mask fetch and extent of the normalized shape
    always_comb begin
        mask = (piece <= 3'd6) ? SHAPES[piece][rot] : 16'h0000;
        for (int i = 0; i < 4; i++) begin
            col_any[i] = mask[i] | mask[4+i] | mask[8+i] | mask[12+i];
            row_any[i] = |mask[4*i +: 4];
        end
        if (col_any[3])      width = 3'd4;
        else if (col_any[2]) width = 3'd3;
        else if (col_any[1]) width = 3'd2;
        else if (col_any[0]) width = 3'd1;
        else                 width = 3'd0;
        if (row_any[3])      height = 3'd4;
        else if (row_any[2]) height = 3'd3;
        else if (row_any[1]) height = 3'd2;
        else if (row_any[0]) height = 3'd1;
        else                 height = 3'd0;
    end

endmodule

// File: rtl/tetris_move_search.sv
// Enumerates every rotation/column drop of a tetromino, has each
// candidate board scored, and keeps the lowest-scoring placement.
module tetris_move_search
    import tetris_pkg::*;
#(
    parameter int ROWS    = tetris_pkg::ROWS,
    parameter int COLS    = tetris_pkg::COLS,
    parameter int SCORE_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           piece,
    input  logic [ROWS*COLS-1:0] board,
    output logic [ROWS*COLS-1:0] cand_board,
    output logic                 req_score,
    input  logic                 recv_score,
    input  logic [SCORE_W-1:0]   score,
    output logic                 busy,
    output logic                 done,
    output logic                 best_valid,
    output logic [1:0]           best_rot,
    output logic [3:0]           best_col,
    output logic [SCORE_W-1:0]   best_score
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS + 1);

    state_e             state;
    logic [2:0]         piece_q;
    logic [N-1:0]       board_q;
    logic [1:0]         rot;
    logic [3:0]         col;
    logic [RW-1:0]      row;
    logic [SCORE_W-1:0] score_q;

    logic [15:0]  mask;
    logic [2:0]   width;
    logic [2:0]   height;
    logic [N-1:0] lane;
    logic [N-1:0] place_cur;
    logic [N-1:0] place_nxt;
    logic         fits_col;
    logic         hit_cur;
    logic         hit_nxt;
    logic         bottom;
    logic         last;
    logic [1:0]   nxt_rot;
    logic [3:0]   nxt_col;

    piece_shape_rom u_rom (
        .piece  (piece_q),
        .rot    (rot),
        .mask   (mask),
        .width  (width),
        .height (height)
    );

    // Shape placed at (row, col) and one row lower, as board bitmaps
    always_comb begin
        place_cur = '0;
        place_nxt = '0;
        lane      = '0;
        for (int r = 0; r < 4; r++) begin
            lane = N'(mask[4*r +: 4]) << col;
            place_cur |= lane << (COLS * (int'(row) + r));
            place_nxt |= lane << (COLS * (int'(row) + r + 1));
        end
    end

    // Legality, drop-stop tests and next candidate in scan order
    always_comb begin
        fits_col = (5'(col) + 5'(width)) <= 5'(COLS);
        hit_cur  = |(place_cur & board_q);
        hit_nxt  = |(place_nxt & board_q);
        bottom   = (int'(row) + int'(height)) >= ROWS;
        last     = (rot == 2'd3) && (col == 4'(COLS - 1));
        nxt_rot  = rot;
        nxt_col  = col + 4'd1;
        if (col == 4'(COLS - 1)) begin
            nxt_rot = rot + 2'd1;
            nxt_col = '0;
        end
    end

    // Search FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            piece_q    <= '0;
            board_q    <= '0;
            rot        <= '0;
            col        <= '0;
            row        <= '0;
            score_q    <= '0;
            cand_board <= '0;
            req_score  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            best_valid <= 1'b0;
            best_rot   <= '0;
            best_col   <= '0;
            best_score <= '0;
        end else begin
            done      <= 1'b0;
            req_score <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        piece_q    <= piece;
                        board_q    <= board;
                        rot        <= '0;
                        col        <= '0;
                        row        <= '0;
                        busy       <= 1'b1;
                        best_valid <= 1'b0;
                        best_rot   <= '0;
                        best_col   <= '0;
                        best_score <= '0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (mask == 16'h0 || !fits_col || hit_cur) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            rot   <= nxt_rot;
                            col   <= nxt_col;
                            row   <= '0;
                            state <= S_LOAD;
                        end
                    end else begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (bottom || hit_nxt) begin
                        cand_board <= board_q | place_cur;
                        req_score  <= 1'b1;
                        state      <= S_REQ;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    if (recv_score) begin
                        score_q <= score;
                        state   <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (!best_valid ||
                        $signed(score_q) < $signed(best_score)) begin
                        best_valid <= 1'b1;
                        best_rot   <= rot;
                        best_col   <= col;
                        best_score <= score_q;
                    end
                    if (last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rot   <= nxt_rot;
                        col   <= nxt_col;
                        row   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_move_search.sv
// Bench for tetris_move_search: stub analyzer, coordinate-based
// placement model and a scoreboard checked on every done pulse.
module tb_tetris_move_search;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int SW   = 32;
    localparam int N    = ROWS * COLS;

    // cells as r*10+c, [piece I,O,T,S,Z,J,L][rot][cell]
    localparam int SH [7][4][4] = '{
        '{'{0,1,2,3},   '{0,10,20,30},  '{0,1,2,3},    '{0,10,20,30}},
        '{'{0,1,10,11}, '{0,1,10,11},   '{0,1,10,11},  '{0,1,10,11}},
        '{'{0,1,2,11},  '{1,10,11,21},  '{1,10,11,12}, '{0,10,11,20}},
        '{'{1,2,10,11}, '{0,10,11,21},  '{1,2,10,11},  '{0,10,11,21}},
        '{'{0,1,11,12}, '{1,10,11,20},  '{0,1,11,12},  '{1,10,11,20}},
        '{'{0,10,11,12},'{0,1,10,20},   '{0,1,2,12},   '{1,11,20,21}},
        '{'{2,10,11,12},'{0,10,20,21},  '{0,1,2,10},   '{0,1,11,21}}
    };

    typedef struct { int rot; int col; logic [N-1:0] cb; } cand_t;
    typedef struct { bit v; int rot; int col; int sc; } res_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     piece = '0;
    logic [N-1:0]   board = '0;
    logic [N-1:0]   cand_board;
    logic           req_score;
    logic           recv_score = 1'b0;
    logic [SW-1:0]  score = '0;
    logic           busy;
    logic           done;
    logic           best_valid;
    logic [1:0]     best_rot;
    logic [3:0]     best_col;
    logic [SW-1:0]  best_score;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;
    int n_req = 0;
    int last_reqs = 0;
    int req_rot [4];
    int score_tab [4][COLS];
    cand_t cand_q [$];
    res_t  exp_q [$];
    logic [N-1:0] cb_log [$];

    tetris_move_search #(
        .ROWS(ROWS), .COLS(COLS), .SCORE_W(SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .piece      (piece),
        .board      (board),
        .cand_board (cand_board),
        .req_score  (req_score),
        .recv_score (recv_score),
        .score      (score),
        .busy       (busy),
        .done       (done),
        .best_valid (best_valid),
        .best_rot   (best_rot),
        .best_col   (best_col),
        .best_score (best_score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_cb(input string nm, input logic [N-1:0] act,
                          input logic [N-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit fits(input logic [N-1:0] b, input int p,
                                input int rt, input int row, input int col);
        for (int k = 0; k < 4; k++) begin
            int r;
            int c;
            r = row + SH[p][rt][k] / 10;
            c = col + SH[p][rt][k] % 10;
            if (r >= ROWS || c >= COLS) return 1'b0;
            if (b[COLS*r + c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: scan all placements, drop, pick lowest score (first on tie)
    task automatic plan(input int p, input logic [N-1:0] b);
        res_t  res;
        cand_t cd;
        int    row;
        res.v = 0; res.rot = 0; res.col = 0; res.sc = 0;
        for (int rt = 0; rt < 4; rt++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!fits(b, p, rt, 0, c)) continue;
                row = 0;
                while (fits(b, p, rt, row + 1, c)) row++;
                cd.rot = rt;
                cd.col = c;
                cd.cb  = b;
                for (int k = 0; k < 4; k++)
                    cd.cb[COLS*(row + SH[p][rt][k]/10) + c + SH[p][rt][k]%10] = 1'b1;
                cand_q.push_back(cd);
                if (!res.v || score_tab[rt][c] < res.sc) begin
                    res.v   = 1;
                    res.rot = rt;
                    res.col = c;
                    res.sc  = score_tab[rt][c];
                end
            end
        end
        exp_q.push_back(res);
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < COLS; c++) score_tab[r][c] = v;
    endtask

    task automatic wait_done(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) break;
        end
        if (i == bound) begin
            n_total++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
    endtask

    task automatic go(input int p, input logic [N-1:0] b, input bit poke);
        int nd0;
        int nr0;
        plan(p, b);
        nd0 = n_done;
        nr0 = n_req;
        for (int r = 0; r < 4; r++) req_rot[r] = 0;
        cb_log.delete();
        @(negedge clk);
        piece = 3'(p);
        board = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        board = '0;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (poke) begin
            repeat (5) @(negedge clk);
            piece = 3'((p + 1) % 7);
            board = ~b;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(3000);
        repeat (2) @(negedge clk);
        last_reqs = n_req - nr0;
        chk("done_pulses", 64'(n_done - nd0), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("cands_left", 64'(cand_q.size()), 64'd0);
    endtask

    // Stub analyzer: replies two cycles after each request
    initial begin : stub
        int s;
        cand_t e;
        forever begin
            @(negedge clk);
            if (req_score === 1'b1) begin
                n_req++;
                cb_log.push_back(cand_board);
                s = 0;
                if (cand_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_req: cand_board %h", cand_board);
                end else begin
                    e = cand_q.pop_front();
                    chk_cb("cand_board", cand_board, e.cb);
                    req_rot[e.rot]++;
                    s = score_tab[e.rot][e.col];
                end
                @(negedge clk);
                @(negedge clk);
                recv_score = 1'b1;
                score = 32'(s);
                @(negedge clk);
                recv_score = 1'b0;
            end
        end
    end

    // Monitor: every done pulse is matched against the next expected result
    initial begin : mon
        res_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: rot %0d col %0d",
                             best_rot, best_col);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {best_valid, best_rot, best_col, best_score},
                        {e.v, 2'(e.rot), 4'(e.col), 32'(e.sc)});
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [N-1:0] b;
        logic [N-1:0] ob;
        int h;
        int nd0;
        int i;

        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, done, req_score, best_valid, best_rot,
                         best_col, best_score}, 64'd0);
        chk_cb("rst_cand", cand_board, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // O on empty board, one winning slot
        fill(1000);
        score_tab[2][4] = 7;
        go(1, '0, 0);
        chk("t1_valid", 64'(best_valid), 64'd1);
        chk("t1_rot", 64'(best_rot), 64'd2);
        chk("t1_col", 64'(best_col), 64'd4);
        chk("t1_score", 64'(best_score), 64'd7);

        // T with all ties keeps the first candidate
        fill(50);
        go(2, '0, 0);
        chk("t2_rotcol", {best_rot, best_col}, 64'd0);

        // first O candidate lands in the bottom-left corner
        fill(0);
        score_tab[0][0] = -3;
        go(1, '0, 0);
        ob = '0;
        ob[180] = 1'b1; ob[181] = 1'b1; ob[190] = 1'b1; ob[191] = 1'b1;
        chk_cb("t3_first_cand", (cb_log.size() > 0) ? cb_log[0] : '0, ob);
        chk("t3_score", 64'(best_score), 64'hFFFFFFFD);

        // I: horizontal fits 7 columns, vertical fits 10
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < COLS; c++)
                score_tab[r][c] = int'($urandom_range(0, 40)) - 20;
        go(0, '0, 0);
        chk("t4_rot0", 64'(req_rot[0]), 64'd7);
        chk("t4_rot1", 64'(req_rot[1]), 64'd10);
        chk("t4_rot2", 64'(req_rot[2]), 64'd7);
        chk("t4_rot3", 64'(req_rot[3]), 64'd10);
        chk("t4_total", 64'(last_reqs), 64'd34);

        // top row full: nothing legal
        b = '0;
        b[COLS-1:0] = '1;
        go(5, b, 0);
        chk("t5_reqs", 64'(last_reqs), 64'd0);
        chk("t5_best", {best_valid, best_rot, best_col, best_score}, 64'd0);

        // reset while waiting for a score; late reply must be ignored
        fill(0);
        plan(1, '0);
        @(negedge clk);
        piece = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (i = 0; i < 200; i++) begin
            if (req_score === 1'b1) break;
            @(negedge clk);
        end
        chk("t6_req_seen", 64'(i < 200), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        cand_q.delete();
        nd0 = n_done;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_outs", {busy, done, req_score, best_valid, best_rot,
                        best_col, best_score}, 64'd0);
        chk_cb("t6_cand", cand_board, '0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", 64'(n_done - nd0), 64'd0);
        fill(9);
        score_tab[1][3] = -1;
        go(2, '0, 0);
        chk("t6_restart", {best_rot, best_col}, {2'd1, 4'd3});

        // random boards, pieces and scores; some with a stray start
        for (int t = 0; t < 10; t++) begin
            b = '0;
            h = $urandom_range(0, ROWS - 1);
            for (int r = h; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    b[COLS*r + c] = ($urandom_range(0, 99) < 45);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < COLS; c++)
                    score_tab[r][c] = int'($urandom_range(0, 20)) - 10;
            go(int'($urandom_range(0, 6)), b, t[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tetris_move_search.md
# tetris_move_search

Placement-search controller that sits directly upstream of the board analysis stage. On `start` it enumerates every rotation/column placement of the current tetromino and hard-drops each one onto the current board. It sends each resulting candidate board to the analyzer through the `req_score`/`recv_score` handshake, keeps the lowest-scoring legal placement, and reports it to the game controller as the move to play.

## Interface

Parameters:
- `ROWS`, default 20: board rows; row 0 is the top row.
- `COLS`, default 10: board columns.
- `SCORE_W`, default 32: width of the analyzer score, read as two's complement.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: one-cycle request to begin a search. Ignored while `busy`.
- `piece`, in, 3: tetromino type 0..6 = I,O,T,S,Z,J,L. Sampled on `start`.
- `board`, in, ROWS*COLS: current board, bit `[COLS*r + c]` is the cell at row r, column c. Sampled on `start`.
- `cand_board`, out, ROWS*COLS: candidate board sent to the analyzer.
- `req_score`, out, 1: one-cycle pulse asking the analyzer to score `cand_board`.
- `recv_score`, in, 1: one-cycle pulse from the analyzer; `score` is valid in that cycle.
- `score`, in, SCORE_W: score of the candidate; lower is better.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse when the search is complete.
- `best_valid`, out, 1: at least one legal placement was found.
- `best_rot`, out, 2: rotation of the best placement.
- `best_col`, out, 4: left column of the 4x4 shape box for the best placement.
- `best_score`, out, SCORE_W: score of the best placement.

## Operation

- Shape ROM: 16-bit mask per (piece, rot), bit `[4*r+c]`. Each mask is normalized so the box's top row and left column both contain a cell.
- Enumeration order: rot 0..3 (outer loop), col 0..COLS-1 (inner loop).
- FSM states: IDLE → LOAD → DROP → REQ → WAIT → CMP → (LOAD for the next candidate | DONE) → IDLE.
- IDLE: on `start`, latch `piece` and `board`, clear the best registers, then go to LOAD with rot=0, col=0.
- LOAD: fetch the mask and place the box with its top at row 0.
  - If any cell falls in a column ≥ COLS, or overlaps the board at row 0, the candidate is illegal. Skip to the next candidate; no request is issued.
- DROP: test one row per cycle.
  - If moving down one row would put any cell at row ≥ ROWS, or would overlap the board, stop.
  - Otherwise move down one row.
  - On stop, register `cand_board` = board | shifted mask. Lines are not compacted; the analyzer counts full rows itself.
- REQ: assert `req_score` for exactly one cycle.
- WAIT: hold `cand_board` stable until `recv_score` arrives. `recv_score` is ignored in every other state.
- CMP: signed compare. Replace the best placement only if `score < best_score` or `best_valid`=0, so on a tie the earliest candidate wins.
- DONE: pulse `done` and return to IDLE.
  - The best registers hold their values until the next accepted `start`.
  - With no legal placement: `best_valid`=0 and best_rot/best_col/best_score stay 0.

## Timing

- Reset values: all outputs 0, FSM in IDLE.
- `rst_n` low mid-search: the search aborts immediately and no `done` pulse is produced.
- The analyzer has no reset, so any `recv_score` arriving after reset is discarded because the FSM is not in WAIT.
- Handshake spacing: REQ is entered no earlier than the cycle after `recv_score` is sampled. This guarantees the analyzer is back in its idle state before the next request.
- Latency per legal candidate: 1 (LOAD) + drop rows + 1 (REQ) + analyzer turnaround (2 cycles) + 1 (CMP).
- Illegal candidate: 1 cycle.
- Worst case is 40 candidates of roughly 25 cycles each; `busy` never exceeds 1100 cycles.
- `start` coincident with `done`: ignored.

## Structure

- Package `tetris_pkg` holds:
  - ROWS/COLS constants
  - the piece enum
  - the 7×4 shape mask table
  - the FSM state typedef
- One sub-module `piece_shape_rom`: (piece, rot) → 16-bit mask plus width/height, purely combinational.

## Test plan

The bench uses a stub analyzer with a 2-cycle turnaround and programmable scores.

1. Empty board, piece O, stub returns 1000 except 7 for rot=2,col=4 → `best_rot`=2, `best_col`=4, `best_score`=7, `best_valid`=1, a single `done` pulse.
2. Empty board, piece T, stub always returns 50 → `best_rot`=0, `best_col`=0 (tie keeps the first).
3. Empty board, piece O, rot0/col0 candidate → `cand_board` has exactly bits 180, 181, 190, 191 set; stub returns −3 for it and 0 for all others → `best_score`=32'hFFFFFFFD.
4. Piece I → exactly 7 `req_score` pulses during rot 0 (cols 0..6) and 10 during rot 1; no pulses for columns that fall out of bounds.
5. Row 0 fully occupied → zero `req_score` pulses, `done` pulse with `best_valid`=0 and `best_rot`=`best_col`=`best_score`=0.
6. `rst_n` pulsed low during WAIT, stub's late `recv_score` arrives after reset → all outputs 0, no `done`; a fresh `start` 3 cycles later completes normally.
